// File: rtl/irq_source_unit.sv
// Interrupt source unit: pends peripheral events, masks them, and presents the
// lowest-index eligible source to the core. Optional macro: IRQ_SRC_EDGE_EN.
module irq_source_unit #(
  parameter int N_SRC = 8,
  localparam int ID_W = $clog2(N_SRC)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] src_i,
  input  logic             mask_we_i,
  input  logic [N_SRC-1:0] mask_wdata_i,
  input  logic             irq_ack_i,
  input  logic             irq_ret_i,
  output logic             irq_req_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic             busy_o,
  output logic [N_SRC-1:0] pending_o,
  output logic [N_SRC-1:0] mask_o
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state, state_nxt;
  logic [N_SRC-1:0] pending, mask, src_evt, eligible, ack_clr;
  logic [ID_W-1:0]  cand_id, isr_id;
  logic             any_elig, take_ack;

`ifdef IRQ_SRC_EDGE_EN
  logic [N_SRC-1:0] src_q;

  // History simply tracks src_i, which also gives the reset value it needs.
  always_ff @(posedge clk_i) begin
    src_q <= src_i;
  end

  assign src_evt = src_i & ~src_q;
`else
  assign src_evt = src_i;
`endif

  assign eligible = pending & mask;
  assign any_elig = |eligible;

  // Downward scan so the lowest eligible index is the last one written.
  always_comb begin
    cand_id = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (eligible[k]) cand_id = ID_W'(k);
    end
  end

  assign take_ack = (state == REQ) && irq_ack_i && any_elig;
  assign ack_clr  = take_ack ? (N_SRC'(1) << cand_id) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      pending <= '0;
      mask    <= '0;
      isr_id  <= '0;
    end else begin
      state   <= state_nxt;
      // A new event on the bit being acknowledged keeps it pending.
      pending <= (pending & ~ack_clr) | src_evt;
      if (mask_we_i) mask <= mask_wdata_i;
      if (take_ack) isr_id <= cand_id;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_elig) state_nxt = REQ;
      REQ: begin
        if (!any_elig)      state_nxt = IDLE;
        else if (irq_ack_i) state_nxt = SERVICE;
      end
      SERVICE: if (irq_ret_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    irq_req_o = 1'b0;
    busy_o    = 1'b0;
    irq_id_o  = '0;
    case (state)
      REQ: begin
        irq_req_o = 1'b1;
        irq_id_o  = cand_id;
      end
      SERVICE: begin
        busy_o   = 1'b1;
        irq_id_o = isr_id;
      end
      default: ;
    endcase
  end

  assign pending_o = pending;
  assign mask_o    = mask;

endmodule

// File: tb/tb_irq_source_unit.sv
// Directed, table-driven bench for irq_source_unit at N_SRC=8.
module tb_irq_source_unit;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] src_i = '0;
  logic       mask_we_i = 1'b0;
  logic [7:0] mask_wdata_i = '0;
  logic       irq_ack_i = 1'b0;
  logic       irq_ret_i = 1'b0;
  logic       irq_req_o;
  logic [2:0] irq_id_o;
  logic       busy_o;
  logic [7:0] pending_o;
  logic [7:0] mask_o;

  int checks = 0;
  int failures = 0;

  irq_source_unit #(.N_SRC(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .src_i(src_i),
    .mask_we_i(mask_we_i), .mask_wdata_i(mask_wdata_i),
    .irq_ack_i(irq_ack_i), .irq_ret_i(irq_ret_i),
    .irq_req_o(irq_req_o), .irq_id_o(irq_id_o), .busy_o(busy_o),
    .pending_o(pending_o), .mask_o(mask_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst;
    logic [7:0] src;
    logic       we;
    logic [7:0] wd;
    logic       ack;
    logic       ret;
    logic       e_req;
    logic [2:0] e_id;
    logic       e_busy;
    logic [7:0] e_pend;
    logic [7:0] e_mask;
  } vec_t;

  vec_t vq[$];

  task automatic row(input logic rst, input logic [7:0] src, input logic we,
                     input logic [7:0] wd, input logic ack, input logic ret,
                     input logic e_req, input logic [2:0] e_id, input logic e_busy,
                     input logic [7:0] e_pend, input logic [7:0] e_mask);
    vec_t v;
    v.rst = rst; v.src = src; v.we = we; v.wd = wd; v.ack = ack; v.ret = ret;
    v.e_req = e_req; v.e_id = e_id; v.e_busy = e_busy;
    v.e_pend = e_pend; v.e_mask = e_mask;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [7:0] src, input logic we,
                       input logic [7:0] wd, input logic ack, input logic ret);
    @(negedge clk_i);
    rst_i = rst; src_i = src; mask_we_i = we; mask_wdata_i = wd;
    irq_ack_i = ack; irq_ret_i = ret;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    //   rst src   we wd    ack ret | req id busy pend   mask
    // reset, single pulse on src 5 through a full service
    row(1, 8'h00, 0, 8'h00, 0, 0,   0, 0, 0, 8'h00, 8'h00);
    row(0, 8'h00, 1, 8'hFF, 0, 0,   0, 0, 0, 8'h00, 8'hFF);
    row(0, 8'h20, 0, 8'h00, 0, 0,   0, 0, 0, 8'h20, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 0,   1, 5, 0, 8'h20, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 1, 0,   0, 5, 1, 8'h00, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 0,   0, 5, 1, 8'h00, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 8'h00, 8'hFF);
    // src 2 and 6 together: 2 first, 6 one cycle after return
    row(0, 8'h44, 0, 8'h00, 0, 0,   0, 0, 0, 8'h44, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 0,   1, 2, 0, 8'h44, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 1, 0,   0, 2, 1, 8'h40, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 8'h40, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 0,   1, 6, 0, 8'h40, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 1, 0,   0, 6, 1, 8'h00, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 8'h00, 8'hFF);
    // masked away while requesting, then unmasked
    row(0, 8'h08, 0, 8'h00, 0, 0,   0, 0, 0, 8'h08, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 0,   1, 3, 0, 8'h08, 8'hFF);
    row(0, 8'h00, 1, 8'h00, 0, 0,   1, 0, 0, 8'h08, 8'h00);
    row(0, 8'h00, 0, 8'h00, 0, 0,   0, 0, 0, 8'h08, 8'h00);
    row(0, 8'h00, 1, 8'h08, 0, 0,   0, 0, 0, 8'h08, 8'h08);
    row(0, 8'h00, 0, 8'h00, 0, 0,   1, 3, 0, 8'h08, 8'h08);
    row(0, 8'h00, 0, 8'h00, 1, 0,   0, 3, 1, 8'h00, 8'h08);
    row(0, 8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 8'h00, 8'h08);
    // higher-priority event pends during service of ID 1
    row(0, 8'h02, 1, 8'hFF, 0, 0,   0, 0, 0, 8'h02, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 0,   1, 1, 0, 8'h02, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 1, 0,   0, 1, 1, 8'h00, 8'hFF);
    row(0, 8'h01, 0, 8'h00, 0, 0,   0, 1, 1, 8'h01, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 0,   0, 1, 1, 8'h01, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 8'h01, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 0,   1, 0, 0, 8'h01, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 1, 0,   0, 0, 1, 8'h00, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 8'h00, 8'hFF);
    // ack of ID 4 coincides with a new src 4 event: set wins
    row(0, 8'h10, 0, 8'h00, 0, 0,   0, 0, 0, 8'h10, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 0,   1, 4, 0, 8'h10, 8'hFF);
    row(0, 8'h10, 0, 8'h00, 1, 0,   0, 4, 1, 8'h10, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 0,   0, 4, 1, 8'h10, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 8'h10, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 0,   1, 4, 0, 8'h10, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 1, 0,   0, 4, 1, 8'h00, 8'hFF);
    // reset mid-service, stray return, masked pending, reset mid-request
    row(1, 8'h00, 0, 8'h00, 0, 0,   0, 0, 0, 8'h00, 8'h00);
    row(0, 8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 8'h00, 8'h00);
    row(0, 8'h01, 0, 8'h00, 0, 0,   0, 0, 0, 8'h01, 8'h00);
    row(0, 8'h00, 0, 8'h00, 0, 0,   0, 0, 0, 8'h01, 8'h00);
    row(0, 8'h00, 1, 8'hFF, 0, 0,   0, 0, 0, 8'h01, 8'hFF);
    row(0, 8'h00, 0, 8'h00, 0, 0,   1, 0, 0, 8'h01, 8'hFF);
    row(1, 8'h00, 0, 8'h00, 0, 0,   0, 0, 0, 8'h00, 8'h00);
    row(0, 8'h00, 0, 8'h00, 1, 0,   0, 0, 0, 8'h00, 8'h00);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].src, vq[i].we, vq[i].wd, vq[i].ack, vq[i].ret);
      chk($sformatf("v%0d.req", i),  {7'b0, irq_req_o}, {7'b0, vq[i].e_req});
      chk($sformatf("v%0d.id", i),   {5'b0, irq_id_o},  {5'b0, vq[i].e_id});
      chk($sformatf("v%0d.busy", i), {7'b0, busy_o},    {7'b0, vq[i].e_busy});
      chk($sformatf("v%0d.pend", i), pending_o,         vq[i].e_pend);
      chk($sformatf("v%0d.mask", i), mask_o,            vq[i].e_mask);
    end

    // ret ignored in REQ, ack ignored in SERVICE, bounded wait for request
    drive(0, 8'h00, 1, 8'hFF, 0, 0);
    drive(0, 8'h80, 0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 8'h00, 0, 0);
    begin
      int n = 0;
      while (!irq_req_o && n < 20) begin
        drive(0, 8'h00, 0, 8'h00, 0, 0);
        n++;
      end
      chk("seq.req_wait", {7'b0, irq_req_o}, 8'h01);
    end
    chk("seq.req_id7", {5'b0, irq_id_o}, 8'h07);
    drive(0, 8'h00, 0, 8'h00, 0, 1);
    chk("seq.ret_in_req", {7'b0, irq_req_o}, 8'h01);
    drive(0, 8'h00, 0, 8'h00, 1, 0);
    chk("seq.svc_busy", {7'b0, busy_o}, 8'h01);
    drive(0, 8'h00, 0, 8'h00, 1, 0);
    chk("seq.ack_in_svc_busy", {7'b0, busy_o}, 8'h01);
    chk("seq.ack_in_svc_id", {5'b0, irq_id_o}, 8'h07);
    drive(0, 8'h00, 0, 8'h00, 0, 1);
    chk("seq.ret_idle", {7'b0, busy_o | irq_req_o}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_source_unit.md
IRQ_SOURCE_UNIT -- requirements
Module: irq_source_unit

Interface
REQ-001 SHALL have parameter N_SRC, default 8, number of peripheral interrupt sources (2..32).
REQ-002 SHALL derive ID_W = clog2(N_SRC) (3 at default) for ID widths.
REQ-003 clk_i  input  1  sole clock, rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 src_i  input  N_SRC  raw peripheral interrupt lines, synchronous to clk_i.
REQ-006 mask_we_i  input  1  mask register write strobe.
REQ-007 mask_wdata_i  input  N_SRC  mask write data; bit=1 enables the source.
REQ-008 irq_ack_i  input  1  core accepted the interrupt (the core's irq_o pulse).
REQ-009 irq_ret_i  input  1  core returned from the handler (the core's irq_ret_o).
REQ-010 irq_req_o  output  1  request to the core (feeds the core's irq_req_i).
REQ-011 irq_id_o  output  ID_W  ID of the in-service source; candidate ID while requesting.
REQ-012 busy_o  output  1  high while an interrupt is in service.
REQ-013 pending_o  output  N_SRC  pending register, for software readback.
REQ-014 mask_o  output  N_SRC  current mask register.

Function
REQ-015 Pending bit k SHALL set on a source event for k (see Configuration).
REQ-016 Bit k is eligible when pending[k] & mask[k]; the candidate is the lowest eligible index (index 0 = highest priority).
REQ-017 FSM states: IDLE, REQ, SERVICE.
REQ-018 IDLE -> REQ on the first cycle any source is eligible; IDLE holds while none is eligible.
REQ-019 In REQ, irq_req_o SHALL be 1 and irq_id_o SHALL show the combinational candidate.
REQ-020 REQ -> SERVICE on irq_ack_i=1: latch the candidate into the in-service ID and clear its pending bit in the same edge.
REQ-021 REQ -> IDLE with no ack if no source remains eligible (mask write or clear); irq_req_o drops the next cycle.
REQ-022 In SERVICE, irq_req_o=0, busy_o=1, and irq_id_o holds the latched ID while new events continue to pend.
REQ-023 SERVICE -> IDLE on irq_ret_i=1; REQ may re-enter on the following cycle if any source is eligible (one cycle of irq_req_o=0 minimum between services).
REQ-024 Ignore irq_ack_i in IDLE and SERVICE; ignore irq_ret_i in IDLE and REQ.
REQ-025 If an event and the ack-clear hit the same bit in one cycle, set SHALL win (bit stays pending).
REQ-026 Mask write SHALL take effect at the next edge; masking never clears pending bits.
REQ-027 All outputs registered except irq_id_o in REQ; request latency from event to irq_req_o = 2 cycles in IDLE.
REQ-028 irq_id_o SHALL be 0 in IDLE.

Reset
REQ-029 rst_i=1 at a clock edge SHALL force IDLE, pending=0, mask=0, in-service ID=0, and the edge-history register = current src_i.
REQ-030 Reset mid-SERVICE or mid-REQ SHALL abandon the interrupt with no ack or return required; irq_req_o=0 and busy_o=0 on the cycle after reset.

Configuration
REQ-031 Macro IRQ_SRC_EDGE_EN selects edge detection.
REQ-032 With IRQ_SRC_EDGE_EN defined, an event is a 0->1 transition of src_i[k] versus the previous cycle; one edge produces one pending set regardless of pulse length.
REQ-033 Without it, sources are level-sensitive: pending[k] sets every cycle src_i[k]=1, so a held line re-pends immediately after the ack-clear.

Verification
REQ-034 Reset, mask=0xFF, pulse src_i[5] for 1 cycle -> irq_req_o=1 two cycles later, irq_id_o=5; ack -> busy_o=1, pending_o[5]=0; ret -> IDLE, irq_req_o=0.
REQ-035 Mask=0xFF, src_i[2] and src_i[6] rise together -> ID 2 serviced first; after ret, irq_req_o reasserts one cycle later with irq_id_o=6.
REQ-036 Event on src 3 in REQ, then write mask=0x00 before ack -> irq_req_o falls, FSM returns to IDLE, pending_o[3] stays 1; write mask=0x08 -> request reasserts with ID 3.
REQ-037 In SERVICE with ID 1, pulse src_i[0] -> irq_req_o stays 0 and pending_o[0]=1; ret -> REQ with irq_id_o=0.
REQ-038 Same-cycle ack for ID 4 and new src_i[4] edge -> ID 4 in service and pending_o[4]=1 afterwards.
REQ-039 Assert rst_i during SERVICE -> next cycle busy_o=0, irq_req_o=0, pending_o=0, mask_o=0; a stray irq_ret_i then has no effect.
